// File: rtl/mult_div_unit.sv
// Multiply/divide unit feeding the HI/LO register pair.
// Signed operands are reduced to magnitudes on accept. An unsigned shift-add multiply
// (or a single-cycle multiply) or a restoring divide runs on those magnitudes. FIX then
// restores the result signs, and WRITE strobes HI/LO for one cycle.
module mult_div_unit #(
  parameter int FAST_MULT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic        HI_write_enable,
  output logic        LO_write_enable,
  output logic [31:0] HI_write_data,
  output logic [31:0] LO_write_data
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] MUL   = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] FIX   = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;

  logic [2:0]  state, state_next;
  logic [5:0]  count, count_next;
  // Multiply: {partial product high, remaining multiplier bits}; divide: {remainder, quotient}
  logic [63:0] acc, acc_next;
  // Multiplicand for multiply, divisor magnitude for divide
  logic [31:0] opnd, opnd_next;
  logic        is_div, is_div_next;
  logic        neg_q, neg_q_next;      // product / quotient must be negated
  logic        neg_r, neg_r_next;      // remainder must be negated
  logic [31:0] hi_data_next, lo_data_next;

  logic        accept, op_signed, op_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  // Operand conditioning and per-iteration datapath
  always_comb begin
    accept    = (state == IDLE) && start && !flush;
    op_signed = ~op[0];
    op_div    = op[1];
    mag_a     = (op_signed && operand_a[31]) ? (32'd0 - operand_a) : operand_a;
    mag_b     = (op_signed && operand_b[31]) ? (32'd0 - operand_b) : operand_b;
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opnd};
    prod_fix  = neg_q ? (64'd0 - acc) : acc;
    quot_fix  = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix   = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
  end

  // Next-state and datapath update
  always_comb begin
    state_next   = state;
    count_next   = count;
    acc_next     = acc;
    opnd_next    = opnd;
    is_div_next  = is_div;
    neg_q_next   = neg_q;
    neg_r_next   = neg_r;
    hi_data_next = HI_write_data;
    lo_data_next = LO_write_data;
    case (state)
      IDLE: begin
        if (accept) begin
          count_next  = 6'd0;
          is_div_next = op_div;
          neg_q_next  = op_signed && (operand_a[31] ^ operand_b[31]);
          neg_r_next  = op_signed && operand_a[31];
          if (op_div) begin
            acc_next  = {32'd0, mag_a};
            opnd_next = mag_b;
            if (operand_b == 32'd0) begin
              // Divide by zero skips the iterations entirely
              hi_data_next = operand_a;
              lo_data_next = 32'hFFFF_FFFF;
              state_next   = WRITE;
            end else begin
              state_next = DIV;
            end
          end else begin
            acc_next   = {32'd0, mag_b};
            opnd_next  = mag_a;
            state_next = MUL;
          end
        end
      end
      MUL: begin
        if (flush) begin
          state_next = IDLE;
        end else if (FAST_MULT != 0) begin
          acc_next   = {32'd0, opnd} * {32'd0, acc[31:0]};
          state_next = FIX;
        end else begin
          acc_next   = {mul_sum, acc[31:1]};
          count_next = count + 6'd1;
          if (count == 6'd31) state_next = FIX;
        end
      end
      DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (!div_diff[32]) acc_next = {div_diff[31:0], acc[30:0], 1'b1};
          else               acc_next = {div_shift[31:0], acc[30:0], 1'b0};
          count_next = count + 6'd1;
          if (count == 6'd31) state_next = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          if (is_div) begin
            hi_data_next = rem_fix;
            lo_data_next = quot_fix;
          end else begin
            hi_data_next = prod_fix[63:32];
            lo_data_next = prod_fix[31:0];
          end
          state_next = WRITE;
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      count         <= 6'd0;
      acc           <= 64'd0;
      opnd          <= 32'd0;
      is_div        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      HI_write_data <= 32'd0;
      LO_write_data <= 32'd0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      acc           <= acc_next;
      opnd          <= opnd_next;
      is_div        <= is_div_next;
      neg_q         <= neg_q_next;
      neg_r         <= neg_r_next;
      HI_write_data <= hi_data_next;
      LO_write_data <= lo_data_next;
    end
  end

  // Strobes; a flush in WRITE kills the strobe in that same cycle
  always_comb begin
    busy            = (state != IDLE);
    done            = (state == WRITE) && !flush;
    HI_write_enable = done;
    LO_write_enable = done;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, random ops against a plain
// arithmetic model, and hand sequences for start/flush/reset during an operation.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;

  logic        busy, done, hi_we, lo_we;
  logic [31:0] hi_wd, lo_wd;
  logic        f_busy, f_done, f_hi_we, f_lo_we;
  logic [31:0] f_hi_wd, f_lo_wd;

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit #(.FAST_MULT(0)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .HI_write_enable(hi_we), .LO_write_enable(lo_we),
    .HI_write_data(hi_wd), .LO_write_data(lo_wd)
  );

  mult_div_unit #(.FAST_MULT(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(f_busy), .done(f_done),
    .HI_write_enable(f_hi_we), .LO_write_enable(f_lo_we),
    .HI_write_data(f_hi_wd), .LO_write_data(f_lo_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero and the
  // remainder follows the dividend, matching the required sign rules.
  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo);
    longint      sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; {hi, lo} = p; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  // action: 0 none, 1 second start in cycle 10, 2 flush in cycle 10,
  //         3 reset in cycle 10, 4 flush in cycle 34
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int action, output int scyc, output int scount,
                        output logic [31:0] shi, output logic [31:0] slo,
                        output int fcyc, output logic [31:0] fhi, output logic [31:0] flo,
                        output int busy_last, output int incoh);
    scyc = 0; scount = 0; shi = 0; slo = 0; fcyc = 0; fhi = 0; flo = 0;
    busy_last = 0; incoh = 0;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (action == 1 && n == 10);
      flush = (action == 2 && n == 10) || (action == 4 && n == 34);
      reset = !(action == 3 && n == 10);
      if (n == 1 || n == 10) begin
        op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      end
      #1;
      if (busy) busy_last = n;
      if ((hi_we !== lo_we) || (hi_we !== done)) incoh++;
      if ((f_hi_we !== f_lo_we) || (f_hi_we !== f_done)) incoh++;
      if (hi_we) begin scount++; scyc = n; shi = hi_wd; slo = lo_wd; end
      if (f_hi_we) begin fcyc = n; fhi = f_hi_wd; flo = f_lo_wd; end
    end
    start = 1'b0; flush = 1'b0; reset = 1'b1;
  endtask

  task automatic apply_and_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ehi,
                                 input logic [31:0] elo, input int ecyc);
    int scyc, scount, fcyc, busy_last, incoh, efcyc;
    logic [31:0] shi, slo, fhi, flo;
    run_op(o, a, b, 0, scyc, scount, shi, slo, fcyc, fhi, flo, busy_last, incoh);
    efcyc = (o[1] == 1'b0) ? 3 : ecyc;
    check({tag, " strobes"}, 64'(scount), 64'd1);
    check({tag, " cycle"}, 64'(scyc), 64'(ecyc));
    check({tag, " HI"}, {32'd0, shi}, {32'd0, ehi});
    check({tag, " LO"}, {32'd0, slo}, {32'd0, elo});
    check({tag, " busy_last"}, 64'(busy_last), 64'(ecyc));
    check({tag, " fast cycle"}, 64'(fcyc), 64'(efcyc));
    check({tag, " fast HI/LO"}, {fhi, flo}, {ehi, elo});
    check({tag, " coherent"}, 64'(incoh), 64'd0);
  endtask

  initial begin
    int scyc, scount, fcyc, busy_last, incoh;
    logic [31:0] shi, slo, fhi, flo, ehi, elo;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
    vecs[2]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 34};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[4]  = '{2'd3, 32'd7,         32'd2,         32'd1,         32'd3,         34};
    vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[6]  = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[7]  = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[8]  = '{2'd0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 34};
    vecs[9]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[10] = '{2'd1, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         34};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset strobes", {61'd0, done, hi_we, lo_we}, 64'd0);
    check("reset data", {hi_wd, lo_wd}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i])
      apply_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].hi, vecs[i].lo, vecs[i].cyc);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 6 == 0) ra = 32'h8000_0000;
      model(ro, ra, rb, ehi, elo);
      apply_and_check($sformatf("rand%0d", i), ro, ra, rb, ehi, elo,
                      (ro[1] && rb == 32'd0) ? 1 : 34);
    end

    // Second start during a DIV is ignored
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, scyc, scount, shi, slo, fcyc, fhi, flo,
           busy_last, incoh);
    check("restart strobes", 64'(scount), 64'd1);
    check("restart cycle", 64'(scyc), 64'd34);
    check("restart HI/LO", {shi, slo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Flush mid-DIV
    run_op(2'd3, 32'd1000, 32'd3, 2, scyc, scount, shi, slo, fcyc, fhi, flo,
           busy_last, incoh);
    check("flush strobes", 64'(scount), 64'd0);
    check("flush busy_last", 64'(busy_last), 64'd10);
    apply_and_check("after flush", 2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 34);

    // Reset mid-DIV: prior result (1, 3) in the data registers must be cleared
    run_op(2'd2, 32'd1000, 32'd3, 3, scyc, scount, shi, slo, fcyc, fhi, flo,
           busy_last, incoh);
    check("reset-mid strobes", 64'(scount), 64'd0);
    check("reset-mid busy_last", 64'(busy_last), 64'd9);
    check("reset-mid data", {hi_wd, lo_wd}, 64'd0);
    apply_and_check("after reset", 2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF,
                    32'hFFFF_FFF1, 34);

    // Flush during WRITE
    run_op(2'd3, 32'd9, 32'd4, 4, scyc, scount, shi, slo, fcyc, fhi, flo,
           busy_last, incoh);
    check("flush-write strobes", 64'(scount), 64'd0);
    check("flush-write busy_last", 64'(busy_last), 64'd34);

    // Flush together with start in IDLE: start ignored
    @(negedge clk);
    op = 2'd1; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush+start busy", 64'(busy), 64'd0);
    check("flush+start fast busy", 64'(f_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
